// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } dmem_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int CNT_W          = 4;

   // Word-index width for a given depth; never less than one bit.
   function automatic int idx_width(input int depth);
      int w;
      for (w = 1; w < 31; w++) begin
         if ((1 << w) >= depth) break;
      end
      return w;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with byte-enabled synchronous write and registered read
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = 10
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic                      rd_en,
   input  logic [IDX_W-1:0]          idx,
   input  logic [31:0]               wdata,
   input  logic [BYTES_PER_WORD-1:0] be,
   output logic [31:0]               rdata
);

   logic [31:0] mem [DEPTH];

   // Contents and the read register are deliberately outside reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (rd_en) rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data-memory slave; DMEM_BYTE_ENABLE_EN enables byte-masked stores
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        err,
   output logic        busy
);

   localparam int IDX_W = idx_width(DEPTH_WORDS);

   dmem_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       be_q;
   logic             rd_vld;

   logic [31:0]      off;
   logic [31:0]      word_off;
   logic             acc_err;
   logic             do_access;
   logic [3:0]       wr_be;
   logic [31:0]      rd_word;

   // Unsigned compare against the base first so low addresses never wrap into range.
   assign off       = addr_q - BASE_ADDR;
   assign word_off  = off >> 2;
   assign acc_err   = (addr_q < BASE_ADDR) || (word_off >= 32'(DEPTH_WORDS)) ||
                      (addr_q[1:0] != 2'b00);
   assign do_access = (state == ACCESS) && (cnt == '0);

`ifdef DMEM_BYTE_ENABLE_EN
   assign wr_be = be_q;
`else
   logic unused_be;
   assign wr_be     = 4'hF;
   assign unused_be = ^be_q;
`endif

   dmem_array #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .wr_en (do_access && we_q && !acc_err),
      .rd_en (do_access && !we_q && !acc_err),
      .idx   (word_off[IDX_W-1:0]),
      .wdata (wdata_q),
      .be    (wr_be),
      .rdata (rd_word)
   );

   // The read register holds its word until the next access; rd_vld zeroes it for stores and errors.
   assign rdata = rd_word & {32{rd_vld}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         ack     <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         rd_vld  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ack <= 1'b0;
               err <= 1'b0;
               if (req) begin
                  we_q    <= we;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  be_q    <= be;
                  cnt     <= CNT_W'(WAIT_CYCLES);
                  busy    <= 1'b1;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  ack    <= 1'b1;
                  err    <= acc_err;
                  rd_vld <= !acc_err && !we_q;
                  state  <= RESP;
               end
            end
            RESP: begin
               ack   <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (one and zero wait states)
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, req0, we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic [31:0] rdata1, rdata0;
   logic        ack1, err1, busy1;
   logic        ack0, err0, busy0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h1001_0000),
      .WAIT_CYCLES (1)
   ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .be    (be),
      .rdata (rdata1),
      .ack   (ack1),
      .err   (err1),
      .busy  (busy1)
   );

   dmem_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h1001_0000),
      .WAIT_CYCLES (0)
   ) u_dut0 (
      .clk   (clk),
      .rst   (rst),
      .req   (req0),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .be    (be),
      .rdata (rdata0),
      .ack   (ack0),
      .err   (err0),
      .busy  (busy0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // sel=0 drives the one-wait-state DUT, sel=1 the zero-wait-state DUT.
   task automatic access(input logic sel, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         output logic [31:0] rd, output logic e, output int lat,
                         output logic bsy);
      logic hit;
      @(negedge clk);
      if (sel) req0 = 1'b1; else req = 1'b1;
      we = w; addr = a; wdata = d; be = b;
      @(negedge clk);
      req = 1'b0; req0 = 1'b0;
      bsy = sel ? busy0 : busy1;
      lat = 0; hit = 1'b0;
      while (!hit && lat < 20) begin
         if (sel ? ack0 : ack1) hit = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      rd = sel ? rdata0 : rdata1;
      e  = sel ? err0 : err1;
   endtask

   task automatic do_store(input logic sel, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, input logic exp_err, input string tag);
      logic [31:0] rd;
      logic        e, bsy;
      int          lat;
      access(sel, 1'b1, a, d, b, rd, e, lat, bsy);
      check({tag, "_lat"}, 32'(lat), sel ? 32'd1 : 32'd2);
      check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
      check({tag, "_rdata"}, rd, 32'd0);
   endtask

   task automatic do_load(input logic sel, input logic [31:0] a, input logic [31:0] exp_d,
                          input logic exp_err, input string tag);
      logic [31:0] rd;
      logic        e, bsy;
      int          lat;
      access(sel, 1'b0, a, 32'd0, 4'hF, rd, e, lat, bsy);
      check({tag, "_lat"}, 32'(lat), sel ? 32'd1 : 32'd2);
      check({tag, "_busy"}, {31'd0, bsy}, 32'd1);
      check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
      check({tag, "_rdata"}, rd, exp_d);
   endtask

   initial begin
      int acks;
      int first_ack;
      rst = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0;
      addr = '0; wdata = '0; be = 4'h0;
      repeat (3) @(negedge clk);
      check("rst_ack", {31'd0, ack1}, 32'd0);
      check("rst_err", {31'd0, err1}, 32'd0);
      check("rst_busy", {31'd0, busy1}, 32'd0);
      check("rst_rdata", rdata1, 32'd0);
      check("rst_ack0", {31'd0, ack0}, 32'd0);
      rst = 1'b0;

      do_store(1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, "st4");
      do_load (1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, "ld4");
      @(negedge clk);
      check("hold_ack", {31'd0, ack1}, 32'd0);
      check("hold_rdata", rdata1, 32'hDEAD_BEEF);

      // Misaligned and out-of-range accesses must not touch memory.
      do_load (1'b0, 32'h1001_0002, 32'd0, 1'b1, "ld_mis");
      do_store(1'b0, 32'h1001_0005, 32'h0, 4'hF, 1'b1, "st_mis");
      do_load (1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, "ld4_again");
      do_store(1'b0, 32'h1001_0000, 32'h0123_4567, 4'hF, 1'b0, "st0");
      do_store(1'b0, 32'h1001_0FFC, 32'h1234_5678, 4'hF, 1'b0, "st_last");
      do_load (1'b0, 32'h1000_FFFC, 32'd0, 1'b1, "ld_below");
      do_load (1'b0, 32'h1001_1000, 32'd0, 1'b1, "ld_above");
      do_store(1'b0, 32'h1000_FFFC, 32'hFFFF_FFFF, 4'hF, 1'b1, "st_below");
      do_store(1'b0, 32'h1001_1000, 32'hFFFF_FFFF, 4'hF, 1'b1, "st_above");
      do_load (1'b0, 32'h1001_0FFC, 32'h1234_5678, 1'b0, "ld_last");
      do_load (1'b0, 32'h1001_0000, 32'h0123_4567, 1'b0, "ld0");

      // Reset during the wait state of a store discards it without an ack.
      do_store(1'b0, 32'h1001_0008, 32'h55AA_55AA, 4'hF, 1'b0, "pre8");
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h1001_0008; wdata = 32'h0BAD_F00D; be = 4'hF;
      @(negedge clk);
      req = 1'b0;
      check("mid_busy", {31'd0, busy1}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy1}, 32'd0);
      acks = 0;
      repeat (3) begin
         @(negedge clk);
         if (ack1) acks++;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (ack1) acks++;
      end
      check("rst_no_ack", 32'(acks), 32'd0);
      do_load(1'b0, 32'h1001_0008, 32'h55AA_55AA, 1'b0, "ld8_after_rst");

      do_store(1'b0, 32'h1001_000C, 32'h1122_3344, 4'hF, 1'b0, "pre_c");
      do_store(1'b0, 32'h1001_000C, 32'hAABB_CCDD, 4'b0101, 1'b0, "st_be");
`ifdef DMEM_BYTE_ENABLE_EN
      do_load (1'b0, 32'h1001_000C, 32'h11BB_33DD, 1'b0, "ld_be");
      do_store(1'b0, 32'h1001_000C, 32'h0000_0000, 4'b0000, 1'b0, "st_be0");
      do_load (1'b0, 32'h1001_000C, 32'h11BB_33DD, 1'b0, "ld_be0");
`else
      do_load (1'b0, 32'h1001_000C, 32'hAABB_CCDD, 1'b0, "ld_be");
      do_store(1'b0, 32'h1001_000C, 32'h0000_0000, 4'b0000, 1'b0, "st_be0");
      do_load (1'b0, 32'h1001_000C, 32'h0000_0000, 1'b0, "ld_be0");
`endif

      // Zero wait states: req held over 8 edges is accepted at edges 0, 3 and 6 only.
      do_store(1'b1, 32'h1001_0004, 32'hCAFE_F00D, 4'hF, 1'b0, "w0_st");
      do_load (1'b1, 32'h1001_0004, 32'hCAFE_F00D, 1'b0, "w0_ld");
      @(negedge clk);
      req0 = 1'b1; we = 1'b0; addr = 32'h1001_0004; be = 4'hF;
      acks = 0; first_ack = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 7) req0 = 1'b0;
         if (ack0) begin
            acks++;
            if (first_ack < 0) first_ack = i;
         end
      end
      check("w0_acks", 32'(acks), 32'd3);
      check("w0_first_ack", 32'(first_ack), 32'd1);
      check("w0_rdata", rdata0, 32'hCAFE_F00D);
      check("w0_busy_end", {31'd0, busy0}, 32'd0);
      check("w1_idle_ack", {31'd0, ack1}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
